// File: rtl/toplayici_hakemi_if.sv
// Request/result handshake bundle for the two-requester shared adder arbiter.
// Slave side is the arbiter; master side is the requester pair.
interface toplayici_hakemi_if #(
    parameter int unsigned BIT = 32
);
    logic [1:0]       istek_gecerli_i;
    logic [1:0]       istek_hazir_o;
    logic [2*BIT-1:0] istek_a_i;
    logic [2*BIT-1:0] istek_b_i;
    logic [1:0]       istek_islem_i;
    logic [1:0]       sonuc_gecerli_o;
    logic [1:0]       sonuc_hazir_i;
    logic [BIT-1:0]   sonuc_o;
    logic             tasma_o;

    modport slave (
        input  istek_gecerli_i,
        input  istek_a_i,
        input  istek_b_i,
        input  istek_islem_i,
        input  sonuc_hazir_i,
        output istek_hazir_o,
        output sonuc_gecerli_o,
        output sonuc_o,
        output tasma_o
    );

    modport master (
        output istek_gecerli_i,
        output istek_a_i,
        output istek_b_i,
        output istek_islem_i,
        output sonuc_hazir_i,
        input  istek_hazir_o,
        input  sonuc_gecerli_o,
        input  sonuc_o,
        input  tasma_o
    );
endinterface

// File: rtl/toplayici_hakemi.sv
// Round-robin arbiter sharing one carry-lookahead add/subtract unit between two requesters.
// Parallel-prefix adder lives in this file alongside the arbiter that owns it.

module carry_lookahead_toplayici #(
    parameter int unsigned BIT = 32
) (
    input  logic [BIT-1:0] a_i,
    input  logic [BIT-1:0] b_i,
    input  logic           cin_i,
    output logic [BIT-1:0] sum_o
);
    localparam int unsigned Levels = $clog2(BIT);

    logic [BIT-1:0] p;
    logic [BIT-1:0] g;
    logic [BIT-1:0] carry;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Kogge-Stone prefix; carry-in occupies position 0 so gv[i] ends up as the carry into bit i.
    always_comb begin
        logic [BIT-1:0] gv;
        logic [BIT-1:0] pv;
        logic [BIT-1:0] gn;
        logic [BIT-1:0] pn;
        gv = {g[BIT-2:0], cin_i};
        pv = {p[BIT-2:0], 1'b0};
        gn = gv;
        pn = pv;
        for (int l = 0; l < int'(Levels); l++) begin
            gn = gv;
            pn = pv;
            for (int i = (1 << l); i < int'(BIT); i++) begin
                gn[i] = gv[i] | (pv[i] & gv[i - (1 << l)]);
                pn[i] = pv[i] & pv[i - (1 << l)];
            end
            gv = gn;
            pv = pn;
        end
        carry = gv;
    end

    assign sum_o = p ^ carry;
endmodule

module toplayici_hakemi #(
    parameter int unsigned BIT = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    toplayici_hakemi_if.slave hakem
);
    typedef enum logic [1:0] {StBosta, StHesapla, StSonuc} durum_e;

    durum_e         durum_q;
    logic           oncelik_q;
    logic           sahip_q;
    logic           islem_q;
    logic [BIT-1:0] a_q;
    logic [BIT-1:0] b_q;
    logic [BIT-1:0] sonuc_q;
    logic           tasma_q;
    logic [1:0]     sonuc_gecerli_q;

    logic [1:0]     hazir;
    logic [BIT-1:0] b_eff;
    logic [BIT-1:0] toplam;
    logic           tasma;

    // Grant is combinational so a lone requester is accepted in the cycle it raises valid.
    always_comb begin
        hazir = 2'b00;
        if (rst_ni && durum_q == StBosta) begin
            unique case (hakem.istek_gecerli_i)
                2'b01:   hazir = 2'b01;
                2'b10:   hazir = 2'b10;
                2'b11:   hazir = oncelik_q ? 2'b10 : 2'b01;
                default: hazir = 2'b00;
            endcase
        end
    end

    assign b_eff = islem_q ? ~b_q : b_q;

    carry_lookahead_toplayici #(
        .BIT(BIT)
    ) u_toplayici (
        .a_i  (a_q),
        .b_i  (b_eff),
        .cin_i(islem_q),
        .sum_o(toplam)
    );

    // Overflow uses the true operand B sign, not the inverted one fed to the adder.
    always_comb begin
        if (islem_q) begin
            tasma = (a_q[BIT-1] != b_q[BIT-1]) && (toplam[BIT-1] != a_q[BIT-1]);
        end else begin
            tasma = (a_q[BIT-1] == b_q[BIT-1]) && (toplam[BIT-1] != a_q[BIT-1]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q         <= StBosta;
            oncelik_q       <= 1'b0;
            sahip_q         <= 1'b0;
            islem_q         <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            sonuc_q         <= '0;
            tasma_q         <= 1'b0;
            sonuc_gecerli_q <= 2'b00;
        end else begin
            unique case (durum_q)
                StBosta: begin
                    if (hazir != 2'b00) begin
                        a_q       <= hazir[1] ? hakem.istek_a_i[BIT +: BIT] : hakem.istek_a_i[0 +: BIT];
                        b_q       <= hazir[1] ? hakem.istek_b_i[BIT +: BIT] : hakem.istek_b_i[0 +: BIT];
                        islem_q   <= hakem.istek_islem_i[hazir[1]];
                        sahip_q   <= hazir[1];
                        oncelik_q <= ~hazir[1];
                        durum_q   <= StHesapla;
                    end
                end
                StHesapla: begin
                    sonuc_q         <= toplam;
                    tasma_q         <= tasma;
                    sonuc_gecerli_q <= sahip_q ? 2'b10 : 2'b01;
                    durum_q         <= StSonuc;
                end
                StSonuc: begin
                    if (hakem.sonuc_hazir_i[sahip_q]) begin
                        sonuc_gecerli_q <= 2'b00;
                        durum_q         <= StBosta;
                    end
                end
                default: durum_q <= StBosta;
            endcase
        end
    end

    assign hakem.istek_hazir_o   = hazir;
    assign hakem.sonuc_gecerli_o = sonuc_gecerli_q;
    assign hakem.sonuc_o         = sonuc_q;
    assign hakem.tasma_o         = tasma_q;
endmodule

// File: doc/toplayici_hakemi.md
TOPLAYICI_HAKEMI -- requirements
Module: toplayici_hakemi

Interface
REQ-001 SHALL have parameter BIT, default 32, operand/result width.
REQ-002 SHALL have clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have istek_gecerli_i  input  2  request valid, bit k = requester k.
REQ-005 SHALL have istek_hazir_o  output  2  request ready (grant), bit k = requester k.
REQ-006 SHALL have istek_a_i  input  2*BIT  operand A, requester k in bits [k*BIT +: BIT].
REQ-007 SHALL have istek_b_i  input  2*BIT  operand B, same packing.
REQ-008 SHALL have istek_islem_i  input  2  operation, 0 = A+B, 1 = A-B.
REQ-009 SHALL have sonuc_gecerli_o  output  2  result valid, bit k = owner requester k.
REQ-010 SHALL have sonuc_hazir_i  input  2  result ready from requester k.
REQ-011 SHALL have sonuc_o  output  BIT  result, shared by both requesters.
REQ-012 SHALL have tasma_o  output  1  signed overflow of the result, qualified by sonuc_gecerli_o.

Function
REQ-013 SHALL share one carry_lookahead_toplayici instance (BIT wide) between the two requesters; no second adder.
REQ-014 SHALL implement FSM states BOSTA, HESAPLA, SONUC.
REQ-015 BOSTA: with no istek_gecerli_i bit set, SHALL stay in BOSTA with istek_hazir_o = 2'b00.
REQ-016 BOSTA: with exactly one request valid, SHALL assert that bit of istek_hazir_o combinationally in the same cycle.
REQ-017 BOSTA: with both requests valid, SHALL grant the requester selected by round-robin pointer oncelik (1 bit); the other hazir bit SHALL stay 0.
REQ-018 Handshake: a request is accepted on a rising edge where istek_gecerli_i[k] & istek_hazir_o[k].
REQ-019 On acceptance, SHALL register A, B, islem and owner index k, and transition to HESAPLA.
REQ-020 On acceptance, SHALL set oncelik to ~k; a lone requester therefore also flips the pointer.
REQ-021 istek_hazir_o SHALL be 2'b00 in HESAPLA and SONUC; at most one hazir bit is ever set.
REQ-022 HESAPLA: SHALL drive the adder from the registered operands, register sum into sonuc_o, register overflow into tasma_o, and transition to SONUC; duration exactly one cycle.
REQ-023 Overflow rule, add: tasma = (A[msb]==B[msb]) & (S[msb]!=A[msb]).
REQ-024 Overflow rule, subtract: tasma = (A[msb]!=B[msb]) & (S[msb]!=A[msb]).
REQ-025 Arithmetic SHALL be modulo 2^BIT; carry-out SHALL be discarded.
REQ-026 SONUC: SHALL assert sonuc_gecerli_o[owner] only; the other bit SHALL be 0.
REQ-027 SONUC: sonuc_o and tasma_o SHALL be held stable until sonuc_hazir_i[owner] is sampled high.
REQ-028 SONUC: on sonuc_hazir_i[owner] high, SHALL return to BOSTA on that edge; sonuc_hazir_i of the non-owner SHALL be ignored.
REQ-029 Latency: with result ready held high, result valid SHALL appear on the second edge after acceptance.
REQ-030 Throughput: at most one operation per 3 cycles; no new grant in the cycle a result is consumed.
REQ-031 Requests that drop istek_gecerli_i before being granted SHALL be lost without side effects.
REQ-032 Requester inputs SHALL be ignored outside BOSTA.

Reset
REQ-033 While rst_ni = 0, SHALL force state BOSTA, oncelik = 0, sonuc_o = 0, tasma_o = 0, sonuc_gecerli_o = 0, istek_hazir_o = 0, and clear all operand registers, independent of clk_i.
REQ-034 Reset asserted in HESAPLA or SONUC SHALL abort the operation; no result is delivered after release.
REQ-035 After rst_ni deasserts, the first grant under contention SHALL go to requester 0.

Verification
REQ-036 Single add: req0 A=0x00000005, B=0x00000003, islem=0, ready held high -> hazir_o=01 same cycle; sonuc_gecerli_o=01 two edges later, sonuc_o=0x00000008, tasma_o=0.
REQ-037 Subtract with overflow: req1 A=0x80000000, B=0x00000001, islem=1 -> sonuc_gecerli_o=10, sonuc_o=0x7FFFFFFF, tasma_o=1.
REQ-038 Contention: both valid continuously after reset -> grants alternate 0,1,0,1 and results return to the matching owner; sonuc_o = 0xFFFFFFFF for A=0xFFFFFFFE, B=1 add, tasma_o=0.
REQ-039 Backpressure: sonuc_hazir_i[0]=0 for 5 cycles in SONUC -> sonuc_gecerli_o=01 and sonuc_o stable for all 5 cycles; istek_hazir_o=00 throughout, even with req1 valid.
REQ-040 Reset mid-op: rst_ni low during HESAPLA -> all outputs 0 asynchronously; after release with no requests, sonuc_gecerli_o stays 00.
REQ-041 Wrap: A=0xFFFFFFFF, B=0x00000001 add -> sonuc_o=0x00000000, tasma_o=0.
